// File: rtl/bin_to_bcd_n_if.sv
// Start/busy/done handshake and data bus of the binary-to-BCD converter.
// bin_in and bcd keep MSB-first [0:W-1] ordering to match the upstream counter.
interface bin_to_bcd_n_if #(
    parameter int N = 7,
    parameter int D = 3
);
    logic           start;
    logic [0:N-1]   bin_in;
    logic           busy;
    logic           done;
    logic [0:4*D-1] bcd;

    modport master (output start, bin_in, input  busy, done, bcd);
    modport slave  (input  start, bin_in, output busy, done, bcd);
endinterface

// File: rtl/bin_to_bcd_n.sv
// Sequential double-dabble converter: one bit per clock, N steps per conversion.
// bcd is written only on completion, so it never shows partial values.
module bin_to_bcd_n #(
    parameter int N = 7,
    parameter int D = 3
) (
    input  logic          clk,
    input  logic          clr,
    bin_to_bcd_n_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     sh_q, sh_d;
    logic [4*D-1:0]   scr_q, scr_d;
    logic [4*D-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [4*D-1:0]   adj;

    // Per-nibble add-3 correction; 4-bit wrap is safe when 10^D > 2^N - 1.
    function automatic logic [4*D-1:0] add3(input logic [4*D-1:0] s);
        logic [4*D-1:0] r;
        logic [3:0]     nib;
        r = s;
        for (int i = 0; i < D; i++) begin
            nib = s[4*i +: 4];
            r[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        adj     = add3(scr_q);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh_d    = bus.bin_in;
                    scr_d   = '0;
                    cnt_d   = CW'(N);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, sh_d} = {adj[4*D-2:0], sh_q, 1'b0};
                cnt_d         = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = scr_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            sh_q    <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_n.sv
// Directed bench for bin_to_bcd_n: reset, corner values, handshake, abort and a
// free-running counter source.
module tb_bin_to_bcd_n;
    logic clk = 1'b0;
    logic clr;
    int   n_vec = 0;
    int   n_err = 0;
    logic [6:0] cnt;

    bin_to_bcd_n_if #(.N(7), .D(3)) bus ();
    bin_to_bcd_n #(.N(7), .D(3)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    // Stand-in for counter_N #(7): free-running 7-bit count, cleared by clr.
    always @(posedge clk) begin
        if (clr) cnt <= '0;
        else     cnt <= cnt + 7'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Full conversion from IDLE; checks busy window, latency, result and bcd hold.
    task automatic convert(input int v, input logic [11:0] exp, input logic [11:0] prev);
        bus.bin_in = 7'(v);
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("conv_busy", 32'(bus.busy), 32'd1);
            chk("conv_hold", 32'(bus.bcd), 32'(prev));
            if (i == 3) bus.bin_in = 7'd0;
            step();
        end
        chk("conv_done", 32'(bus.done), 32'd1);
        chk("conv_bcd", 32'(bus.bcd), 32'(exp));
        step();
        chk("conv_done_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        int ndone, gap, cap, last_drv, prev_cnt;
        logic prev_busy, wrapped, fin;
        clr = 1'b1;
        bus.start = 1'b1;
        bus.bin_in = 7'd100;

        // reset held with start high
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            chk("rst_bcd", 32'(bus.bcd), 32'h000);
        end
        clr = 1'b0;
        bus.start = 1'b0;
        step();
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_bcd", 32'(bus.bcd), 32'h000);

        // max value (bin_in dropped to 0 mid-conversion) and corners
        convert(127, 12'h127, 12'h000);
        convert(0,   12'h000, 12'h127);
        convert(99,  12'h099, 12'h000);
        convert(100, 12'h100, 12'h099);
        convert(9,   12'h009, 12'h100);

        // start re-asserted at E3 while busy: only one done
        bus.bin_in = 7'd55;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (bus.done) ndone++;
        end
        chk("ignore_start_dones", 32'(ndone), 32'd1);
        chk("ignore_start_bcd", 32'(bus.bcd), 32'h055);

        // start held high: done every 8 cycles, bcd stable between pulses
        bus.bin_in = 7'd33;
        bus.start = 1'b1;
        gap = 0;
        for (int i = 0; i < 12 && !bus.done; i++) step();
        chk("hold_first_done", 32'(bus.done), 32'd1);
        for (int p = 0; p < 2; p++) begin
            gap = 0;
            do begin
                step();
                gap++;
                if (!bus.done) chk("hold_bcd_stable", 32'(bus.bcd), 32'h033);
            end while (!bus.done && gap < 12);
            chk("hold_period", 32'(gap), 32'd8);
            chk("hold_bcd", 32'(bus.bcd), 32'h033);
        end
        bus.start = 1'b0;
        for (int i = 0; i < 12 && bus.busy; i++) step();
        chk("hold_idle", 32'(bus.busy), 32'd0);

        // abort with clr at E4
        bus.bin_in = 7'd85;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_bcd", 32'(bus.bcd), 32'h000);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        convert(42, 12'h042, 12'h000);

        // counter-driven: restart after every done until the count wraps
        wrapped = 1'b0;
        fin = 1'b0;
        ndone = 0;
        cap = 0;
        for (int i = 0; i < 600 && !fin; i++) begin
            bus.bin_in = cnt;
            last_drv = int'(cnt);
            bus.start = 1'b1;
            prev_busy = bus.busy;
            prev_cnt = int'(cnt);
            step();
            if (prev_cnt == 127 && cnt == 7'd0) wrapped = 1'b1;
            if (bus.busy && !prev_busy) cap = last_drv;
            if (bus.done) begin
                chk("sys_bcd", 32'(bus.bcd), 32'(to_bcd(cap)));
                ndone++;
                if (wrapped) fin = 1'b1;
            end
        end
        bus.start = 1'b0;
        chk("sys_wrapped", 32'(fin), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
